// File: rtl/recognition_pkg.sv
// Shared types and constants for the word-to-serial recogniser sequencer.
// Optional macro RECOG_FIRST_POS_EN adds first-match position reporting in the top.
package recognition_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_REC_LAT = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Bits needed to hold values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/recognition_lat_pipe.sv
// REC_LAT-deep valid pipe: marks the cycles in which rec_out belongs to a presented bit.
// Latency DEPTH cycles; no backpressure, synchronous clear, asynchronous active-high reset.
module recognition_lat_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic in_i,
  output logic out_o
);

  logic [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_q <= '0;
    end else if (clr_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= in_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign out_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/recognition_seq_ctrl.sv
// Feeds a serial sequence recogniser MSB-first from parallel words and returns per-word match counts.
// Latency 1+WIDTH+REC_LAT cycles to res_valid; holds the result until res_ready. Macro: RECOG_FIRST_POS_EN.
module recognition_seq_ctrl
  import recognition_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int REC_LAT = DEF_REC_LAT,
  localparam int CNT_W   = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             rec_reset,
  output logic             rec_in,
  input  logic             rec_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
`ifdef RECOG_FIRST_POS_EN
  output logic [CNT_W-1:0] res_first,
`endif
  output logic             busy
);

  localparam int BC_W = cnt_width((WIDTH > REC_LAT) ? WIDTH : REC_LAT);
  localparam logic [BC_W-1:0]  SHIFT_LAST = BC_W'(WIDTH - 1);
  localparam logic [BC_W-1:0]  DRAIN_LAST = BC_W'(REC_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(WIDTH);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              accept, pipe_out, hit;

  assign accept = in_valid && (state_q == ST_IDLE);
  // Only rec_out cycles aligned to a presented bit of this word may count.
  assign hit    = pipe_out && rec_out && (count_q != CNT_MAX);

  recognition_lat_pipe #(.DEPTH(REC_LAT)) u_lat_pipe (
    .clk   (clk),
    .reset (reset),
    .clr_i (accept),
    .in_i  (state_q == ST_SHIFT),
    .out_o (pipe_out)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    count_d  = hit ? count_q + CNT_W'(1) : count_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d  = in_data;
          count_d  = '0;
          bitcnt_d = '0;
          state_d  = ST_CLR;
        end
      end
      ST_CLR: begin
        bitcnt_d = '0;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        shreg_d = shreg_q << 1;
        if (bitcnt_q == SHIFT_LAST) begin
          bitcnt_d = '0;
          state_d  = ST_DRAIN;
        end else begin
          bitcnt_d = bitcnt_q + BC_W'(1);
        end
      end
      ST_DRAIN: begin
        if (bitcnt_q == DRAIN_LAST) begin
          bitcnt_d = '0;
          state_d  = ST_DONE;
        end else begin
          bitcnt_d = bitcnt_q + BC_W'(1);
        end
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      count_q  <= count_d;
    end
  end

`ifdef RECOG_FIRST_POS_EN
  logic [CNT_W-1:0] pos_q, pos_d, first_q, first_d;

  // pos_q counts presented bits already seen at the pipe output, so pos_q+1 is 1-based.
  always_comb begin
    pos_d   = pipe_out ? pos_q + CNT_W'(1) : pos_q;
    first_d = (hit && count_q == '0) ? pos_q + CNT_W'(1) : first_q;
    if (accept) begin
      pos_d   = '0;
      first_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q   <= '0;
      first_q <= '0;
    end else begin
      pos_q   <= pos_d;
      first_q <= first_d;
    end
  end

  assign res_first = first_q;
`endif

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rec_reset = (state_q == ST_IDLE) || (state_q == ST_CLR);
  assign rec_in    = (state_q == ST_SHIFT) ? shreg_q[WIDTH-1] : 1'b0;
  assign res_valid = (state_q == ST_DONE);
  assign res_count = count_q;

endmodule

// File: tb/tb_recognition_seq_ctrl.sv
// Scoreboard bench for recognition_seq_ctrl with a Moore "101" overlapping recogniser, WIDTH=8, REC_LAT=1.
module tb_recognition_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       rec_reset, rec_in, rec_out;
  logic       res_valid, res_ready;
  logic [3:0] res_count;
  logic       busy;
`ifdef RECOG_FIRST_POS_EN
  logic [3:0] res_first;
`endif

  always #5 clk = ~clk;

  recognition_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rec_reset (rec_reset),
    .rec_in    (rec_in),
    .rec_out   (rec_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_count (res_count),
`ifdef RECOG_FIRST_POS_EN
    .res_first (res_first),
`endif
    .busy      (busy)
  );

  // Moore recogniser: 0 idle, 1 seen "1", 2 seen "10", 3 seen "101" (output high).
  logic [1:0] rs_q = 2'd0;
  always @(posedge clk) begin
    if (rec_reset) rs_q <= 2'd0;
    else begin
      case (rs_q)
        2'd0:    rs_q <= rec_in ? 2'd1 : 2'd0;
        2'd1:    rs_q <= rec_in ? 2'd1 : 2'd2;
        2'd2:    rs_q <= rec_in ? 2'd3 : 2'd0;
        default: rs_q <= rec_in ? 2'd1 : 2'd2;
      endcase
    end
  end
  assign rec_out = (rs_q == 2'd3);

  typedef struct {
    int count;
    int first;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result handshake is presented.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (in_valid && in_ready) n_acc++;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("res_count", int'(res_count), e.count);
`ifdef RECOG_FIRST_POS_EN
          check("res_first", int'(res_first), e.first);
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int i = 0;
    while (!in_ready && i < 200) begin
      tick();
      i++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [7:0] d, input int cnt, input int first, input bit expect_res);
    exp_t e;
    wait_ready();
    in_valid = 1'b1;
    in_data  = d;
    if (expect_res) begin
      e.count = cnt;
      e.first = first;
      exp_q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic wait_done();
    int i = 0;
    while ((exp_q.size() != 0 || !in_ready) && i < 300) begin
      tick();
      i++;
    end
    if (i >= 300) check("drain_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    int a0;
    int k;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_rec_reset", rec_reset, 1);
    check("rst_rec_in", rec_in, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_count", res_count, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Reset mid-SHIFT aborts the word; the monitor flags any stray result.
    send(8'hA5, 0, 0, 1'b0);
    repeat (4) tick();
    check("pre_abort_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_rec_reset", rec_reset, 1);
    check("abort_res_valid", res_valid, 0);
    check("abort_res_count", res_count, 0);
    tick();
    reset = 1'b0;
    repeat (15) tick();

    // Serial order and latency.
    pat = 8'b10101010;
    send(pat, 3, 3, 1'b1);
    @(negedge clk);
    check("clr_rec_reset", rec_reset, 1);
    check("clr_rec_in", rec_in, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("shift_rec_in", rec_in, pat[7-i]);
      check("shift_rec_reset", rec_reset, 0);
    end
    @(negedge clk);
    check("drain_res_valid", res_valid, 0);
    @(negedge clk);
    check("lat10_res_valid", res_valid, 1);
    wait_done();

    send(8'h00, 0, 0, 1'b1);
    wait_done();
    send(8'hFF, 0, 0, 1'b1);
    wait_done();
    send(8'hA5, 2, 3, 1'b1);
    wait_done();

    // Cross-word isolation, and in_valid held high while busy.
    wait_ready();
    a0 = n_acc;
    begin
      exp_t e;
      e.count = 0;
      e.first = 0;
      exp_q.push_back(e);
    end
    in_valid = 1'b1;
    in_data  = 8'h02;
    tick();
    repeat (10) tick();
    check("hold_busy_in_ready", in_ready, 0);
    in_valid = 1'b0;
    wait_done();
    check("single_accept", n_acc - a0, 1);
    send(8'h80, 0, 0, 1'b1);
    wait_done();

    // Backpressure in DONE.
    res_ready = 1'b0;
    send(8'hAA, 3, 3, 1'b1);
    k = 0;
    while (!res_valid && k < 30) begin
      tick();
      k++;
    end
    check("bp_reach_done", res_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_res_valid", res_valid, 1);
      check("bp_res_count", res_count, 3);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    check("release_res_valid", res_valid, 0);
    check("release_busy", busy, 0);

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
